io_out_uart: RTL and testbench

IO_OUT_UART -- requirements
Module: io_out_uart

---
 rtl/io_uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/io_out_uart.sv | 153 +++++++++++++++
 tb/tb_io_out_uart.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - shared transmit FSM encoding and 8N1 frame constants
package io_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   DATA_BITS      = 8;
    localparam int   BYTES_PER_WORD = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous show-ahead FIFO with push/pop/full/empty/count
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en;

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({wr_en, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/io_out_uart.sv
// rtl/io_out_uart.sv - captures changes of a 32-bit output word and sends them as 8N1 UART bytes
module io_out_uart
    import io_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_in,
    output logic        io_tx,
    output logic        io_busy,
    output logic        io_overflow,
    output logic [4:0]  io_count
);

    localparam int          CW            = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] BAUD_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  BIT_IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [1:0]  BYTE_IDX_LAST = 2'(BYTES_PER_WORD - 1);

    tx_state_e   state_q, state_d;
    logic [31:0] prev_q;
    logic [31:0] shift_q, shift_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    logic        push, pop, baud_done;
    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_rdata;
    logic [CW-1:0] fifo_count;

    assign push      = (io_in != prev_q);
    assign baud_done = (baud_q == BAUD_LAST);
    assign ovf_d     = ovf_q | (push & fifo_full & ~pop);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (io_in),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Change detector and sticky drop flag; a dropped word still updates prev_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= io_in;
            ovf_q  <= ovf_d;
        end
    end

    // Next-state for the framer; the shift register moves one bit per data bit period.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_q == BIT_IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q == BYTE_IDX_LAST) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level follows the state being entered so io_tx stays registered.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            default: tx_d = STOP_BIT;
        endcase
    end

    // Framer state register; reset aborts any frame and returns the line to idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign io_tx       = tx_q;
    assign io_busy     = (state_q != IDLE) || !fifo_empty;
    assign io_overflow = ovf_q;
    assign io_count    = 5'(fifo_count);

endmodule

// File: tb/tb_io_out_uart.sv
// tb/tb_io_out_uart.sv - self-checking bench for io_out_uart
module tb_io_out_uart;

    localparam int C = 4;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] io_in = 32'h0;
    logic        io_tx;
    logic        io_busy;
    logic        io_overflow;
    logic [4:0]  io_count;

    io_out_uart #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_in       (io_in),
        .io_tx       (io_tx),
        .io_busy     (io_busy),
        .io_overflow (io_overflow),
        .io_count    (io_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_q [$];
    logic [31:0] m_prev = 32'h0;
    logic [31:0] m_cur  = 32'h0;
    int          m_t    = 0;
    bit          m_active = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_valid  = 1'b0;

    logic [7:0]  rxq [$];
    logic [7:0]  exp_b [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Line level of cell t of a word: 40*C cells, ten bits per byte, LSB byte first.
    function automatic logic frame_bit(input logic [31:0] w, input int t);
        int b;
        int byt;
        int k;
        b   = t / C;
        byt = b / 10;
        k   = b % 10;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return w[byt * 8 + k - 1];
    endfunction

    // Model update at each edge, compare 2 time units later.
    initial begin : model_proc
        bit pop;
        bit chg;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_q.delete();
                m_prev   = 32'h0;
                m_active = 1'b0;
                m_t      = 0;
                m_ovf    = 1'b0;
                m_valid  = 1'b1;
            end else begin
                pop    = !m_active && (m_q.size() != 0);
                chg    = (io_in != m_prev);
                m_prev = io_in;
                if (m_active) begin
                    m_t++;
                    if (m_t == 40 * C) m_active = 1'b0;
                end
                if (pop) begin
                    m_cur    = m_q.pop_front();
                    m_active = 1'b1;
                    m_t      = 0;
                end
                if (chg) begin
                    if (m_q.size() < D) m_q.push_back(io_in);
                    else m_ovf = 1'b1;
                end
            end
            #2;
            if (m_valid) begin
                check("tx", 32'(io_tx), 32'(m_active ? frame_bit(m_cur, m_t) : 1'b1));
                check("busy", 32'(io_busy), 32'(m_active || (m_q.size() != 0)));
                check("overflow", 32'(io_overflow), 32'(m_ovf));
                check("count", 32'(io_count), 32'(m_q.size()));
            end
        end
    end

    // UART receiver sampling each bit at mid-period.
    initial begin : rx_proc
        logic [7:0] b;
        logic       sb;
        forever begin
            @(posedge clock); #3;
            if (io_tx === 1'b0) begin
                repeat (C / 2) @(posedge clock);
                #3;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(posedge clock);
                    #3;
                    b[i] = io_tx;
                end
                repeat (C) @(posedge clock);
                #3;
                sb = io_tx;
                if (sb === 1'b1) rxq.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    task automatic drive(input logic r, input logic [31:0] v);
        @(negedge clock);
        reset = r;
        io_in = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (io_busy === 1'b1 && n < max) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", 32'(io_busy), 32'h0);
    endtask

    task automatic push_word_bytes(input logic [31:0] w);
        exp_b.push_back(w[7:0]);
        exp_b.push_back(w[15:8]);
        exp_b.push_back(w[23:16]);
        exp_b.push_back(w[31:24]);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_len"}, 32'(rxq.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < rxq.size(); i++) begin
            check(tag, 32'(rxq[i]), 32'(exp_b[i]));
        end
    endtask

    logic [31:0] six [6];
    int          n;

    initial begin : driver
        six[0] = 32'hA1B2C3D4;
        six[1] = 32'h01020304;
        six[2] = 32'hDEADBEEF;
        six[3] = 32'h0BADF00D;
        six[4] = 32'h55AA33CC;
        six[5] = 32'h99999999;

        tick(3);
        check("rst_tx", 32'(io_tx), 32'h1);
        check("rst_busy", 32'(io_busy), 32'h0);
        check("rst_ovf", 32'(io_overflow), 32'h0);
        check("rst_count", 32'(io_count), 32'h0);

        drive(1'b0, 32'h000000A5);
        tick(1);
        check("a5_push_count", 32'(io_count), 32'h1);
        check("a5_push_tx", 32'(io_tx), 32'h1);
        tick(1);
        check("a5_start_tx", 32'(io_tx), 32'h0);
        check("a5_pop_count", 32'(io_count), 32'h0);
        wait_idle(400, n);
        check("a5_line_cycles", 32'(n), 32'd160);
        tick(2);
        exp_b.delete();
        push_word_bytes(32'h000000A5);
        check_rx("a5_rx");

        rxq.delete();
        drive(1'b0, 32'h12345678);
        tick(500);
        check("hold_busy", 32'(io_busy), 32'h0);
        check("hold_count", 32'(io_count), 32'h0);
        exp_b.delete();
        push_word_bytes(32'h12345678);
        check_rx("hold_rx");

        rxq.delete();
        for (int i = 0; i < 6; i++) drive(1'b0, six[i]);
        tick(1);
        check("six_ovf", 32'(io_overflow), 32'h1);
        check("six_count", 32'(io_count), 32'h4);
        wait_idle(1200, n);
        tick(2);
        check("six_ovf_sticky", 32'(io_overflow), 32'h1);
        exp_b.delete();
        for (int i = 0; i < 5; i++) push_word_bytes(six[i]);
        check_rx("six_rx");

        rxq.delete();
        drive(1'b0, 32'hCAFEF00D);
        tick(92);
        drive(1'b1, 32'h00C0FFEE);
        tick(1);
        check("mid_rst_tx", 32'(io_tx), 32'h1);
        check("mid_rst_count", 32'(io_count), 32'h0);
        check("mid_rst_busy", 32'(io_busy), 32'h0);
        check("mid_rst_ovf", 32'(io_overflow), 32'h0);
        check("mid_rst_rx_len", 32'(rxq.size() >= 2), 32'h1);
        if (rxq.size() >= 2) begin
            check("mid_rst_rx0", 32'(rxq[0]), 32'h0D);
            check("mid_rst_rx1", 32'(rxq[1]), 32'hF0);
        end
        tick(60);
        check("in_rst_count", 32'(io_count), 32'h0);
        check("in_rst_busy", 32'(io_busy), 32'h0);
        rxq.delete();
        drive(1'b0, 32'h00C0FFEE);
        tick(1);
        check("post_rst_count", 32'(io_count), 32'h1);
        tick(1);
        check("post_rst_tx", 32'(io_tx), 32'h0);
        wait_idle(400, n);
        tick(2);
        exp_b.delete();
        push_word_bytes(32'h00C0FFEE);
        check_rx("post_rst_rx");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
